// File: rtl/ones_count_pkg.sv
// Shared types and default sizing for the ones-count arbiter slice.
// Used by the interface, the serial core and the arbiter top.
package ones_count_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage : ones_count_pkg

// File: rtl/ones_count_arb_if.sv
// Requester/response bundle between the register-side clients and ones_count_arb.
// The slave modport is the arbiter's view; the master modport is the clients' view.
interface ones_count_arb_if
    import ones_count_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [CW-1:0]         rsp_count;
    logic                  rsp_ready;
    logic                  busy;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_count,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_count,
        output busy
    );

endinterface : ones_count_arb_if

// File: rtl/ones_count_core.sv
// Bit-serial population counter: load captures a word, each enabled cycle
// consumes one LSB, done rises once all WIDTH bits have been consumed.
module ones_count_core
    import ones_count_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          en,
    input  logic [WIDTH-1:0]              load_data,
    output logic [$clog2(WIDTH+1)-1:0]    acc,
    output logic                          done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             done_q, done_d;

    // Shift/accumulate step; shifting stops on its own once done is reached.
    always_comb begin
        sh_d     = sh_q;
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        if (load) begin
            sh_d     = load_data;
            acc_d    = '0;
            bitcnt_d = '0;
        end else if (en && !done_q) begin
            acc_d    = acc_q + CW'(sh_q[0]);
            sh_d     = sh_q >> 1;
            bitcnt_d = bitcnt_q + CW'(1);
        end
        done_d = (bitcnt_d == CW'(WIDTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q     <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
        end
    end

    assign acc  = acc_q;
    assign done = done_q;

endmodule : ones_count_core

// File: rtl/ones_count_arb.sv
// Round-robin arbiter sharing one serial ones-count core among NREQ requesters;
// returns each popcount tagged with the requester ID over a valid/ready channel.
module ones_count_arb
    import ones_count_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    ones_count_arb_if.slave  bus
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [CW-1:0]    rsp_count_q, rsp_count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             any_req_c;
    logic [IDW-1:0]   pick_c;
    logic [IDW-1:0]   cand_c;
    logic [WIDTH-1:0] pick_data_c;
    logic [NREQ-1:0]  req_ready_c;
    logic             core_load_c;
    logic             core_en_c;
    logic [CW-1:0]    core_acc;
    logic             core_done;

    // First valid requester searching upward from ptr+1, wrapping at NREQ.
    always_comb begin
        any_req_c = 1'b0;
        pick_c    = '0;
        cand_c    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = IDW'((32'(ptr_q) + k) % NREQ);
            if (!any_req_c && bus.req_valid[cand_c]) begin
                any_req_c = 1'b1;
                pick_c    = cand_c;
            end
        end
    end

    always_comb begin
        pick_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_c == IDW'(i)) begin
                pick_data_c = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c)                     state_d = COUNT;
            COUNT:   if (core_done)                     state_d = RESP;
            RESP:    if (rsp_valid_q && bus.rsp_ready)  state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
    end

    // Grant, core control and response-register updates.
    always_comb begin
        ptr_d       = ptr_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        core_load_c = 1'b0;
        core_en_c   = 1'b0;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    req_ready_c[pick_c] = 1'b1;
                    core_load_c         = 1'b1;
                    ptr_d               = pick_c;
                    id_d                = pick_c;
                    busy_d              = 1'b1;
                end
            end
            COUNT: begin
                core_en_c = 1'b1;
                if (core_done) begin
                    rsp_count_d = core_acc;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    ones_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load_c),
        .en        (core_en_c),
        .load_data (pick_data_c),
        .acc       (core_acc),
        .done      (core_done)
    );

    // The grant is combinational, so hold it off while reset is asserted.
    assign bus.req_ready = req_ready_c & {NREQ{reset}};
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.busy      = busy_q;

endmodule : ones_count_arb

// File: tb/tb_ones_count_arb.sv
// Self-checking bench for ones_count_arb: directed tables, hand sequences for
// backpressure/fairness/reset, and randomized traffic against a behavioural model.
module tb_ones_count_arb;
    import ones_count_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    ones_count_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    ones_count_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cnt;
    } vec_t;

    vec_t single_t[8];
    vec_t four_t[4];

    bit         pv[NREQ];
    logic [7:0] pd[NREQ];
    int         model_ptr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d);
        bus.req_valid[i] = v;
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One grant/count/response transaction with the expected id and count.
    task automatic run_txn(input string tag, input int exp_id, input int exp_cnt,
                           input bit drop, input bit mutate, input int hold);
        int t;
        int lat;
        bus.rsp_ready = (hold == 0);
        #1;
        t = 0;
        while (bus.req_ready == '0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1) << exp_id);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        if (drop) bus.req_valid[exp_id] = 1'b0;
        if (mutate) bus.req_data[exp_id*WIDTH +: WIDTH] = ~bus.req_data[exp_id*WIDTH +: WIDTH];
        @(negedge clk);
        lat = 0;
        chk({tag, "_count_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_count_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
        chk({tag, "_count"}, 32'(bus.rsp_count), 32'(exp_cnt));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_hold_id"}, 32'(bus.rsp_id), 32'(exp_id));
            chk({tag, "_hold_count"}, 32'(bus.rsp_count), 32'(exp_cnt));
            chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            chk({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    function automatic int rr_next(input int ptr);
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (pv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int seen;
        int g;
        bit any;
        logic [7:0] d;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        reset = 1'b0;

        single_t[0] = '{2, 8'hB5, 5};
        single_t[1] = '{0, 8'h7E, 6};
        single_t[2] = '{3, 8'h80, 1};
        single_t[3] = '{1, 8'h00, 0};
        single_t[4] = '{2, 8'hFF, 8};
        single_t[5] = '{3, 8'h01, 1};
        single_t[6] = '{0, 8'hAA, 4};
        single_t[7] = '{1, 8'hC3, 4};
        four_t[0] = '{0, 8'hFF, 8};
        four_t[1] = '{1, 8'h00, 0};
        four_t[2] = '{2, 8'h0F, 4};
        four_t[3] = '{3, 8'h81, 2};

        do_reset();

        // Single requests; the last one also changes its data after the grant.
        for (int i = 0; i < 8; i++) begin
            set_req(single_t[i].id, 1'b1, single_t[i].data);
            run_txn($sformatf("single%0d", i), single_t[i].id, single_t[i].cnt, 1'b1, i == 7, 0);
        end

        // All four valid from reset resolve in order 0..3.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(four_t[i].id, 1'b1, four_t[i].data);
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("four%0d", i), four_t[i].id, four_t[i].cnt, 1'b1, 1'b0, 0);
        end

        // Backpressure in RESP while another requester waits.
        set_req(0, 1'b1, 8'h3C);
        set_req(2, 1'b1, 8'h07);
        run_txn("bp_first", 0, 4, 1'b1, 1'b0, 5);
        run_txn("bp_second", 2, 3, 1'b1, 1'b0, 0);

        // Fairness between two continuously valid requesters.
        do_reset();
        set_req(0, 1'b1, 8'hF0);
        set_req(3, 1'b1, 8'h03);
        for (int r = 0; r < 4; r++) begin
            run_txn($sformatf("fair%0d", r), (r % 2 == 0) ? 0 : 3, (r % 2 == 0) ? 4 : 2,
                    1'b0, 1'b0, 0);
        end
        bus.req_valid = '0;

        // Reset during the 4th COUNT cycle discards the in-flight request.
        set_req(2, 1'b1, 8'hFF);
        #1;
        chk("midrst_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("midrst_rsp_count", 32'(bus.rsp_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
        set_req(1, 1'b1, 8'h01);
        run_txn("post_rst", 1, 1, 1'b1, 1'b0, 0);

        // Randomized traffic against the round-robin/popcount model.
        do_reset();
        model_ptr = NREQ - 1;
        for (int i = 0; i < int'(NREQ); i++) pv[i] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            any = 1'b0;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    d = 8'($urandom);
                    pv[i] = 1'b1;
                    pd[i] = d;
                    set_req(i, 1'b1, d);
                end
                if (pv[i]) any = 1'b1;
            end
            if (!any) begin
                g = int'($urandom_range(0, NREQ - 1));
                d = 8'($urandom);
                pv[g] = 1'b1;
                pd[g] = d;
                set_req(g, 1'b1, d);
            end
            g = rr_next(model_ptr);
            run_txn($sformatf("rnd%0d", it), g, $countones(pd[g]), 1'b1,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            pv[g] = 1'b0;
            model_ptr = g;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ones_count_arb

// File: doc/ones_count_arb.md
# ones_count_arb

Round-robin arbiter and sequencer that shares one serial ones-count datapath among `NREQ` requesters. Each requester presents a data word with a valid/ready handshake. The block grants one requester at a time and runs the word through the bit-serial counting core. It returns the population count tagged with the requester ID over a valid/ready response channel. It sits between the APB-side register clients and the shared counting resource.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 8: data word width in bits, 2..32.
- `CW`, `$clog2(WIDTH+1)`: count width; derived, do not override.
- `IDW`, `$clog2(NREQ)`: requester ID width; derived.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WIDTH  request words; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit set.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  IDW  index of the requester whose result this is.
- `rsp_count`  out  CW  number of 1 bits in the accepted word.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in COUNT and RESP.

## Operation
FSM states: IDLE, COUNT, RESP.

- **IDLE**
  - If any `req_valid` is high, select the first valid requester searching from `ptr+1` upward, modulo `NREQ`.
  - Drive that requester's `req_ready` bit high combinationally in this cycle.
  - At the clock edge: capture its word into the shift register, clear the accumulator and bit counter, latch its ID, set `ptr` to the granted index, and go to COUNT.
  - `req_ready` is high only in IDLE, and only for the granted index.
- **COUNT**
  - Each cycle: `acc <= acc + sh[0]`, `sh <= sh >> 1`, `bitcnt <= bitcnt + 1`.
  - After exactly `WIDTH` COUNT cycles, register the result into `rsp_count`/`rsp_id` and go to RESP.
- **RESP**
  - `rsp_valid` is high.
  - `rsp_count` and `rsp_id` hold stable until `rsp_valid && rsp_ready`; then go to IDLE.
  - Requests are not accepted in RESP.
- **Requester and accumulator rules**
  - Requesters must hold `req_valid` and `req_data` until granted.
  - Data is sampled only at the grant edge; later changes are ignored.
  - The accumulator is `CW` bits wide and never overflows, because the maximum value is `WIDTH`.

Reset (asserted low, any state, including mid-COUNT):
- State returns to IDLE immediately; the in-flight request is discarded with no response.
- `ptr` is set to `NREQ-1`, so requester 0 has first priority after reset.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_count=0`, `busy=0`.
- Grant edge is E0. `rsp_valid` rises after edge E0+`WIDTH`+1, i.e. the COUNT cycles are E1..E`WIDTH` and RESP is entered at edge E`WIDTH`+1.
- If `rsp_ready` is held high, RESP lasts one cycle and IDLE lasts one cycle before the next grant.
- Maximum throughput is one request per `WIDTH`+3 cycles.
- Simultaneous requests resolve by round-robin only; there is no fixed priority except immediately after reset.
- A `rsp_ready` high while `rsp_valid` is low has no effect.

## Structure
- Package `ones_count_pkg`: state enum typedef (`IDLE`, `COUNT`, `RESP`) and default parameter constants.
- Sub-module `ones_count_core`: the serial datapath, containing the shift register, accumulator and bit counter, with `load`/`done` controls.
- The arbiter FSM, round-robin pointer and response registers live in `ones_count_arb`.

## Test plan
- **Single request:** requester 2 valid with `8'hB5` → `req_ready=4'b0100` for one cycle; `rsp_valid` goes high 9 edges after the grant with `rsp_id=2`, `rsp_count=5`.
- **All four valid from reset:** data `8'hFF`, `8'h00`, `8'h0F`, `8'h81` → grants in order 0, 1, 2, 3; counts 8, 0, 4, 2.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in RESP → `rsp_count`/`rsp_id` stable, `req_ready=0`, `busy=1`; the response completes when `rsp_ready` goes high.
- **Fairness:** requesters 0 and 3 continuously valid → grant sequence 0, 3, 0, 3; requester 3 is never starved.
- **Reset mid-COUNT:** assert `reset` low during the 4th COUNT cycle → all outputs go to 0 immediately and no response is issued for that request. After release, a new request with `8'h01` returns `rsp_count=1`.
- **Data change after grant:** change `req_data` after the grant edge → the result reflects the originally sampled word.
